// File: rtl/dfr_pkg.sv
// Shared types and fixed-point helpers for the DFR output-layer matrix multiplier.
package dfr_pkg;

  // Widest accumulator / data word the saturation helper handles.
  localparam int unsigned SAT_ACC_W  = 192;
  localparam int unsigned SAT_DATA_W = 64;

  typedef enum logic [2:0] {
    MM_IDLE  = 3'd0,
    MM_FETCH = 3'd1,
    MM_ACCUM = 3'd2,
    MM_STORE = 3'd3,
    MM_DONE  = 3'd4
  } mm_state_t;

  // Full product width plus enough headroom for K additions and a sign bit.
  function automatic int unsigned acc_width(input int unsigned data_width, input int unsigned k);
    return 2 * data_width + $clog2(k) + 1;
  endfunction

  // Arithmetic (floor) shift by frac_bits, then clamp into a data_width signed word.
  function automatic logic [SAT_DATA_W-1:0] sat_trunc(input logic signed [SAT_ACC_W-1:0] acc,
                                                       input int unsigned frac_bits,
                                                       input int unsigned data_width);
    logic signed [SAT_ACC_W-1:0] shifted;
    logic signed [SAT_ACC_W-1:0] max_v;
    logic signed [SAT_ACC_W-1:0] min_v;
    logic signed [SAT_ACC_W-1:0] one;
    one     = SAT_ACC_W'(1);
    shifted = acc >>> frac_bits;
    max_v   = (one <<< (data_width - 1)) - one;
    min_v   = ~max_v;
    if (shifted > max_v) return SAT_DATA_W'(max_v);
    if (shifted < min_v) return SAT_DATA_W'(min_v);
    return SAT_DATA_W'(shifted);
  endfunction

endpackage

// File: rtl/dfr_matrix_multiply_mac.sv
// Signed multiply-accumulate register with synchronous clear and enable.
module dfr_mac #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ACC_W      = 68
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [ACC_W-1:0]      acc_next_c
);

  logic signed [2*DATA_WIDTH-1:0] prod_c;
  logic signed [ACC_W-1:0]        acc;

  assign prod_c     = a * b;
  assign acc_next_c = acc + ACC_W'(prod_c);

  // Clear wins over enable so a new element never inherits the previous sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc_next_c;
  end

endmodule

// File: rtl/dfr_matrix_multiply.sv
// Output-layer Y = X * W engine: one shared MAC, single-port X/W read RAMs, Y write RAM.
module dfr_matrix_multiply
  import dfr_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned X_ROWS        = 5,
  parameter int unsigned Y_COLS        = 5,
  parameter int unsigned X_COLS_Y_ROWS = 5,
  parameter int unsigned FRAC_BITS     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] x_addr,
  input  logic [DATA_WIDTH-1:0] x_data,
  output logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [ADDR_WIDTH-1:0] y_addr,
  output logic [DATA_WIDTH-1:0] y_data,
  output logic                  y_wen
);

  localparam int unsigned K     = X_COLS_Y_ROWS;
  localparam int unsigned ACC_W = acc_width(DATA_WIDTH, K);
  localparam int unsigned CNT_W = 32;

  mm_state_t               state, state_n;
  logic [CNT_W-1:0]        i, j, k, i_n, j_n, k_n;
  logic [ADDR_WIDTH-1:0]   x_addr_n, w_addr_n, y_addr_n;
  logic [DATA_WIDTH-1:0]   y_data_n;
  logic                    busy_n, done_n, y_wen_n;
  logic                    mac_clr_c, mac_en_c;
  logic signed [ACC_W-1:0] acc_next_c;

  dfr_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_W      (ACC_W)
  ) u_mac (
    .clk        (clk),
    .rst        (rst),
    .clr        (mac_clr_c),
    .en         (mac_en_c),
    .a          ($signed(x_data)),
    .b          ($signed(w_data)),
    .acc_next_c (acc_next_c)
  );

  // Next-state, counter, address and output-register computation.
  always_comb begin
    state_n   = state;
    i_n       = i;
    j_n       = j;
    k_n       = k;
    x_addr_n  = x_addr;
    w_addr_n  = w_addr;
    y_addr_n  = y_addr;
    y_data_n  = y_data;
    y_wen_n   = 1'b0;
    done_n    = 1'b0;
    mac_clr_c = 1'b0;
    mac_en_c  = 1'b0;
    case (state)
      MM_IDLE: begin
        if (start) begin
          mac_clr_c = 1'b1;
          i_n       = '0;
          j_n       = '0;
          k_n       = '0;
          x_addr_n  = '0;
          w_addr_n  = '0;
          state_n   = MM_FETCH;
        end
      end
      MM_FETCH: state_n = MM_ACCUM;
      MM_ACCUM: begin
        mac_en_c = 1'b1;
        if (k != CNT_W'(K - 1)) begin
          k_n      = k + CNT_W'(1);
          x_addr_n = x_addr + ADDR_WIDTH'(1);
          w_addr_n = w_addr + ADDR_WIDTH'(Y_COLS);
          state_n  = MM_FETCH;
        end else begin
          // Register the finished element so it is presented during STORE.
          y_wen_n  = 1'b1;
          y_addr_n = ADDR_WIDTH'(i) * ADDR_WIDTH'(Y_COLS) + ADDR_WIDTH'(j);
          y_data_n = DATA_WIDTH'(sat_trunc(SAT_ACC_W'(acc_next_c), FRAC_BITS, DATA_WIDTH));
          state_n  = MM_STORE;
        end
      end
      MM_STORE: begin
        mac_clr_c = 1'b1;
        if (i == CNT_W'(X_ROWS - 1) && j == CNT_W'(Y_COLS - 1)) begin
          done_n  = 1'b1;
          state_n = MM_DONE;
        end else begin
          k_n = '0;
          if (j == CNT_W'(Y_COLS - 1)) begin
            j_n = '0;
            i_n = i + CNT_W'(1);
          end else begin
            j_n = j + CNT_W'(1);
          end
          x_addr_n = ADDR_WIDTH'(i_n) * ADDR_WIDTH'(K);
          w_addr_n = ADDR_WIDTH'(j_n);
          state_n  = MM_FETCH;
        end
      end
      MM_DONE: state_n = MM_IDLE;
      default: state_n = MM_IDLE;
    endcase
    busy_n = (state_n != MM_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= MM_IDLE;
      i      <= '0;
      j      <= '0;
      k      <= '0;
      x_addr <= '0;
      w_addr <= '0;
      y_addr <= '0;
      y_data <= '0;
      y_wen  <= 1'b0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      i      <= i_n;
      j      <= j_n;
      k      <= k_n;
      x_addr <= x_addr_n;
      w_addr <= w_addr_n;
      y_addr <= y_addr_n;
      y_data <= y_data_n;
      y_wen  <= y_wen_n;
      done   <= done_n;
      busy   <= busy_n;
    end
  end

endmodule

// File: tb/tb_dfr_matrix_multiply.sv
// Self-checking bench: three parameterisations of dfr_matrix_multiply against an arithmetic model.
module tb_dfr_matrix_multiply;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // a_: 2x2, K=2, integer.  b_: default 5x5x5, Q16.  c_: 1x1, K=1, Q16.
  logic        a_start, a_busy, a_done, a_yw;
  logic [31:0] a_xa, a_xd, a_wa, a_wd, a_ya, a_yd;
  logic        b_start, b_busy, b_done, b_yw;
  logic [31:0] b_xa, b_xd, b_wa, b_wd, b_ya, b_yd;
  logic        c_start, c_busy, c_done, c_yw;
  logic [31:0] c_xa, c_xd, c_wa, c_wd, c_ya, c_yd;

  logic [31:0] a_xm [25], a_wm [25], a_ym [25];
  logic [31:0] b_xm [25], b_wm [25], b_ym [25];
  logic [31:0] c_xm [25], c_wm [25], c_ym [25];

  int a_busy_cyc = 0, a_done_cnt = 0, a_wr_cnt = 0;
  int b_busy_cyc = 0, b_done_cnt = 0, b_wr_cnt = 0;
  int c_busy_cyc = 0, c_done_cnt = 0, c_wr_cnt = 0;
  int a_log[$];
  int b_log[$];

  dfr_matrix_multiply #(.X_ROWS(2), .Y_COLS(2), .X_COLS_Y_ROWS(2), .FRAC_BITS(0)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
    .x_addr(a_xa), .x_data(a_xd), .w_addr(a_wa), .w_data(a_wd),
    .y_addr(a_ya), .y_data(a_yd), .y_wen(a_yw));

  dfr_matrix_multiply u_b (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
    .x_addr(b_xa), .x_data(b_xd), .w_addr(b_wa), .w_data(b_wd),
    .y_addr(b_ya), .y_data(b_yd), .y_wen(b_yw));

  dfr_matrix_multiply #(.X_ROWS(1), .Y_COLS(1), .X_COLS_Y_ROWS(1), .FRAC_BITS(16)) u_c (
    .clk(clk), .rst(rst), .start(c_start), .busy(c_busy), .done(c_done),
    .x_addr(c_xa), .x_data(c_xd), .w_addr(c_wa), .w_data(c_wd),
    .y_addr(c_ya), .y_data(c_yd), .y_wen(c_yw));

  // Registered-read RAM models plus activity counters.
  always @(posedge clk) begin
    a_xd <= (a_xa < 25) ? a_xm[a_xa[4:0]] : 32'h0;
    a_wd <= (a_wa < 25) ? a_wm[a_wa[4:0]] : 32'h0;
    b_xd <= (b_xa < 25) ? b_xm[b_xa[4:0]] : 32'h0;
    b_wd <= (b_wa < 25) ? b_wm[b_wa[4:0]] : 32'h0;
    c_xd <= (c_xa < 25) ? c_xm[c_xa[4:0]] : 32'h0;
    c_wd <= (c_wa < 25) ? c_wm[c_wa[4:0]] : 32'h0;
    if (a_yw && a_ya < 25) a_ym[a_ya[4:0]] <= a_yd;
    if (b_yw && b_ya < 25) b_ym[b_ya[4:0]] <= b_yd;
    if (c_yw && c_ya < 25) c_ym[c_ya[4:0]] <= c_yd;
    if (a_yw) begin a_wr_cnt <= a_wr_cnt + 1; a_log.push_back(int'(a_ya)); end
    if (b_yw) begin b_wr_cnt <= b_wr_cnt + 1; b_log.push_back(int'(b_ya)); end
    if (c_yw) c_wr_cnt <= c_wr_cnt + 1;
    if (a_busy) a_busy_cyc <= a_busy_cyc + 1;
    if (b_busy) b_busy_cyc <= b_busy_cyc + 1;
    if (c_busy) c_busy_cyc <= c_busy_cyc + 1;
    if (a_done) a_done_cnt <= a_done_cnt + 1;
    if (b_done) b_done_cnt <= b_done_cnt + 1;
    if (c_done) c_done_cnt <= c_done_cnt + 1;
  end

  // Reference: exact integer dot product, floor shift, clamp to 32-bit signed.
  function automatic logic [31:0] ref_elem(input logic [31:0] xm [25], input logic [31:0] wm [25],
                                           input int i, input int j, input int kk, input int nc,
                                           input int f);
    logic signed [127:0] s;
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    hi = 128'sh7FFF_FFFF;
    lo = -128'sh8000_0000;
    s  = '0;
    for (int k = 0; k < kk; k++)
      s = s + 128'($signed(xm[i*kk+k])) * 128'($signed(wm[k*nc+j]));
    s = s >>> f;
    if (s > hi) return 32'h7FFF_FFFF;
    if (s < lo) return 32'h8000_0000;
    return s[31:0];
  endfunction

  function automatic logic [31:0] rnd_word();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return 32'($urandom_range(0, 32'h001F_FFFF)) - 32'h0010_0000;
  endfunction

  task automatic pulse(input int which);
    @(negedge clk);
    case (which)
      0:       a_start = 1'b1;
      1:       b_start = 1'b1;
      default: c_start = 1'b1;
    endcase
    @(negedge clk);
    a_start = 1'b0;
    b_start = 1'b0;
    c_start = 1'b0;
  endtask

  task automatic wait_idle(input int which, output bit ok);
    bit bz;
    int n;
    n  = 0;
    bz = (which == 0) ? a_busy : (which == 1) ? b_busy : c_busy;
    while (bz && n < 3000) begin
      @(negedge clk);
      n++;
      bz = (which == 0) ? a_busy : (which == 1) ? b_busy : c_busy;
    end
    ok = !bz;
  endtask

  task automatic fill_b_random();
    for (int n = 0; n < 25; n++) begin
      b_xm[n] = rnd_word();
      b_wm[n] = rnd_word();
    end
    for (int n = 0; n < 25; n++) b_ym[n] = ~ref_elem(b_xm, b_wm, n / 5, n % 5, 5, 5, 16);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
    for (int n = 0; n < 25; n++) begin
      a_xm[n] = '0; a_wm[n] = '0; a_ym[n] = '0;
      b_xm[n] = '0; b_wm[n] = '0; b_ym[n] = '0;
      c_xm[n] = '0; c_wm[n] = '0; c_ym[n] = '0;
    end
    repeat (3) @(negedge clk);
    n_total++;
    if ({b_busy, b_done, b_yw} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {b_busy, b_done, b_yw});
    else n_pass++;
    n_total++;
    if ({b_xa, b_wa, b_ya, b_yd} !== 128'h0) $display("FAIL reset_buses: got %h want 0", {b_xa, b_wa, b_ya, b_yd});
    else n_pass++;
    n_total++;
    if ({a_busy, c_busy} !== 2'b00) $display("FAIL reset_other_busy: got %b want 00", {a_busy, c_busy});
    else n_pass++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_integer();
    logic [31:0] exp_y [4];
    int b0, d0, w0, l0;
    bit ok, ord;
    exp_y = '{32'd19, 32'd22, 32'd43, 32'd50};
    a_xm[0] = 32'd1; a_xm[1] = 32'd2; a_xm[2] = 32'd3; a_xm[3] = 32'd4;
    a_wm[0] = 32'd5; a_wm[1] = 32'd6; a_wm[2] = 32'd7; a_wm[3] = 32'd8;
    b0 = a_busy_cyc; d0 = a_done_cnt; w0 = a_wr_cnt; l0 = a_log.size();
    pulse(0);
    wait_idle(0, ok);
    n_total++;
    if (!ok) $display("FAIL int_timeout: busy=%b want 0", a_busy); else n_pass++;
    for (int n = 0; n < 4; n++) begin
      n_total++;
      if (a_ym[n] !== exp_y[n]) $display("FAIL int_y%0d: got %0d want %0d", n, a_ym[n], exp_y[n]);
      else n_pass++;
    end
    ord = 1'b1;
    for (int n = 0; n < 4 && l0 + n < a_log.size(); n++) if (a_log[l0+n] != n) ord = 1'b0;
    n_total++;
    if (a_wr_cnt - w0 != 4 || !ord) $display("FAIL int_writes: got %0d in_order=%b want 4 1", a_wr_cnt - w0, ord);
    else n_pass++;
    n_total++;
    if (a_done_cnt - d0 != 1) $display("FAIL int_done: got %0d want 1", a_done_cnt - d0); else n_pass++;
    n_total++;
    if (a_busy_cyc - b0 != 21) $display("FAIL int_busy_cycles: got %0d want 21", a_busy_cyc - b0); else n_pass++;
  endtask

  task automatic test_default_latency();
    int b0, d0, w0, l0;
    bit ok, ord;
    logic [31:0] e;
    for (int n = 0; n < 25; n++) begin
      b_xm[n] = (n / 5 == n % 5) ? 32'h0001_0000 : 32'h0;
      b_wm[n] = $urandom;
      b_ym[n] = ~b_wm[n];
    end
    b0 = b_busy_cyc; d0 = b_done_cnt; w0 = b_wr_cnt; l0 = b_log.size();
    pulse(1);
    n_total++;
    if (b_busy !== 1'b1) $display("FAIL lat_busy_after_start: got %b want 1", b_busy); else n_pass++;
    wait_idle(1, ok);
    n_total++;
    if (!ok) $display("FAIL lat_timeout: busy=%b want 0", b_busy); else n_pass++;
    n_total++;
    if (b_busy_cyc - b0 != 276) $display("FAIL lat_busy_cycles: got %0d want 276", b_busy_cyc - b0); else n_pass++;
    n_total++;
    if (b_done_cnt - d0 != 1) $display("FAIL lat_done: got %0d want 1", b_done_cnt - d0); else n_pass++;
    ord = 1'b1;
    for (int n = 0; n < 25 && l0 + n < b_log.size(); n++) if (b_log[l0+n] != n) ord = 1'b0;
    n_total++;
    if (b_wr_cnt - w0 != 25 || !ord) $display("FAIL lat_writes: got %0d in_order=%b want 25 1", b_wr_cnt - w0, ord);
    else n_pass++;
    for (int n = 0; n < 25; n++) begin
      e = ref_elem(b_xm, b_wm, n / 5, n % 5, 5, 5, 16);
      n_total++;
      if (b_ym[n] !== e) $display("FAIL lat_y%0d: got %h want %h", n, b_ym[n], e); else n_pass++;
    end
  endtask

  task automatic test_fixed_sat();
    logic [31:0] xs [8], ws [8], es [8];
    int b0;
    bit ok;
    xs = '{32'h0001_8000, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
    ws = '{32'h0002_0000, 32'h7FFF_FFFF, 32'h0002_0000, 32'h0000_0001, 32'h0, 32'h0, 32'h0, 32'h0};
    es = '{32'h0003_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
    for (int n = 4; n < 8; n++) begin
      c_xm[0] = rnd_word();
      c_wm[0] = rnd_word();
      xs[n] = c_xm[0];
      ws[n] = c_wm[0];
      es[n] = ref_elem(c_xm, c_wm, 0, 0, 1, 1, 16);
    end
    for (int n = 0; n < 8; n++) begin
      c_xm[0] = xs[n];
      c_wm[0] = ws[n];
      c_ym[0] = ~es[n];
      b0 = c_busy_cyc;
      pulse(2);
      wait_idle(2, ok);
      n_total++;
      if (!ok || c_ym[0] !== es[n])
        $display("FAIL fx_case%0d: x=%h w=%h got %h want %h", n, xs[n], ws[n], c_ym[0], es[n]);
      else n_pass++;
      n_total++;
      if (c_busy_cyc - b0 != 4) $display("FAIL fx_busy%0d: got %0d want 4", n, c_busy_cyc - b0); else n_pass++;
    end
    n_total++;
    if (c_wr_cnt != 8 || c_done_cnt != 8) $display("FAIL fx_counts: got %0d/%0d want 8/8", c_wr_cnt, c_done_cnt);
    else n_pass++;
  endtask

  task automatic test_start_ignored();
    int b0, d0, w0, n;
    bit ok;
    logic [31:0] e;
    fill_b_random();
    b0 = b_busy_cyc; d0 = b_done_cnt; w0 = b_wr_cnt;
    pulse(1);
    repeat (40) @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    n = 0;
    while (!b_done && n < 1000) begin @(negedge clk); n++; end
    n_total++;
    if (!b_done) $display("FAIL ign_done_timeout: done=%b want 1", b_done); else n_pass++;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if (b_busy !== 1'b0) $display("FAIL ign_restarted: busy=%b want 0", b_busy); else n_pass++;
    n_total++;
    if (b_busy_cyc - b0 != 276) $display("FAIL ign_busy_cycles: got %0d want 276", b_busy_cyc - b0); else n_pass++;
    n_total++;
    if (b_done_cnt - d0 != 1 || b_wr_cnt - w0 != 25)
      $display("FAIL ign_counts: done=%0d writes=%0d want 1 25", b_done_cnt - d0, b_wr_cnt - w0);
    else n_pass++;
    for (int m = 0; m < 25; m++) begin
      e = ref_elem(b_xm, b_wm, m / 5, m % 5, 5, 5, 16);
      n_total++;
      if (b_ym[m] !== e) $display("FAIL ign_y%0d: got %h want %h", m, b_ym[m], e); else n_pass++;
    end
    wait_idle(1, ok);
  endtask

  task automatic test_reset_mid();
    int b0, w0;
    bit ok;
    logic [31:0] e;
    fill_b_random();
    w0 = b_wr_cnt;
    pulse(1);
    repeat (5) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    n_total++;
    if ({b_busy, b_yw, b_done} !== 3'b000) $display("FAIL rst_mid_flags: got %b want 000", {b_busy, b_yw, b_done});
    else n_pass++;
    n_total++;
    if ({b_xa, b_wa} !== 64'h0) $display("FAIL rst_mid_addr: got %h want 0", {b_xa, b_wa}); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if (b_busy !== 1'b0 || b_wr_cnt != w0)
      $display("FAIL rst_mid_quiet: busy=%b writes=%0d want 0 0", b_busy, b_wr_cnt - w0);
    else n_pass++;
    fill_b_random();
    b0 = b_busy_cyc;
    pulse(1);
    wait_idle(1, ok);
    n_total++;
    if (!ok || b_busy_cyc - b0 != 276) $display("FAIL rst_rerun_busy: got %0d want 276", b_busy_cyc - b0);
    else n_pass++;
    for (int m = 0; m < 25; m++) begin
      e = ref_elem(b_xm, b_wm, m / 5, m % 5, 5, 5, 16);
      n_total++;
      if (b_ym[m] !== e) $display("FAIL rst_rerun_y%0d: got %h want %h", m, b_ym[m], e); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int b0, d0, n;
    bit ok;
    logic [31:0] e;
    fill_b_random();
    b0 = b_busy_cyc; d0 = b_done_cnt;
    pulse(1);
    n = 0;
    while (!b_done && n < 1000) begin @(negedge clk); n++; end
    n_total++;
    if (!b_done) $display("FAIL b2b_done_timeout: done=%b want 1", b_done); else n_pass++;
    for (int m = 0; m < 25; m++) begin
      e = ref_elem(b_xm, b_wm, m / 5, m % 5, 5, 5, 16);
      n_total++;
      if (b_ym[m] !== e) $display("FAIL b2b_first_y%0d: got %h want %h", m, b_ym[m], e); else n_pass++;
    end
    for (int m = 0; m < 25; m++) b_xm[m] = rnd_word();
    for (int m = 0; m < 25; m++) b_ym[m] = ~ref_elem(b_xm, b_wm, m / 5, m % 5, 5, 5, 16);
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    n_total++;
    if (b_busy !== 1'b1) $display("FAIL b2b_second_busy: got %b want 1", b_busy); else n_pass++;
    wait_idle(1, ok);
    n_total++;
    if (!ok || b_busy_cyc - b0 != 552 || b_done_cnt - d0 != 2)
      $display("FAIL b2b_totals: busy=%0d done=%0d want 552 2", b_busy_cyc - b0, b_done_cnt - d0);
    else n_pass++;
    for (int m = 0; m < 25; m++) begin
      e = ref_elem(b_xm, b_wm, m / 5, m % 5, 5, 5, 16);
      n_total++;
      if (b_ym[m] !== e) $display("FAIL b2b_second_y%0d: got %h want %h", m, b_ym[m], e); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_integer();
    test_default_latency();
    test_fixed_sat();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
